// File: rtl/weight_pattern_gen.sv
// rtl/weight_pattern_gen.sv - enumerates N-bit words by popcount range over a valid/ready stream
module weight_pattern_gen #(
  parameter int N    = 4,
  parameter int WMIN = 2,
  parameter int WMAX = 3
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         start,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic [N:0]   count
);

  localparam int PCW = $clog2(N + 1);
  localparam int NC  = 1 << N;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t       state;
  logic [N-1:0] cand;
  logic         mode_q;
  logic         later_qual;
  logic         slot_free;
  logic         handshake;

  // A word qualifies when its popcount sits inside [WMIN, WMAX]; mode inverts
  // the selection. WMIN > WMAX leaves the range empty without special casing.
  function automatic logic qualifies(input logic [N-1:0] w, input logic m);
    logic [PCW-1:0] pc;
    pc = '0;
    for (int i = 0; i < N; i++) begin
      pc = pc + PCW'(w[i]);
    end
    return ((int'(pc) >= WMIN) && (int'(pc) <= WMAX)) ^ m;
  endfunction

  assign slot_free = !out_valid || out_ready;
  assign handshake = out_valid && out_ready;

  // Lookahead: does any candidate above the current one still qualify?
  always_comb begin
    later_qual = 1'b0;
    for (int v = 0; v < NC; v++) begin
      if ((v > int'(cand)) && qualifies(N'(v), mode_q)) begin
        later_qual = 1'b1;
      end
    end
  end

  // Control FSM with registered stream outputs, busy flag and handoff counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      cand      <= '0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      count     <= '0;
    end else begin
      if (handshake) begin
        count <= count + 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            cand   <= '0;
            count  <= '0;
            mode_q <= mode;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          if (slot_free) begin
            if (qualifies(cand, mode_q)) begin
              out_data  <= cand;
              out_valid <= 1'b1;
              out_last  <= !later_qual;
            end else begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
            cand <= cand + 1'b1;
            if (cand == {N{1'b1}}) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (slot_free) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_pattern_gen.sv
// tb/tb_weight_pattern_gen.sv - scoreboard bench for weight_pattern_gen
module tb_weight_pattern_gen;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic       a_start = 1'b0, a_mode = 1'b0, a_ready = 1'b1;
  logic       a_valid, a_last, a_busy;
  logic [3:0] a_data;
  logic [4:0] a_count;

  logic       b_start = 1'b0, b_ready = 1'b1;
  logic       b_valid, b_last, b_busy;
  logic [3:0] b_data;
  logic [4:0] b_count;

  logic       c_start = 1'b0, c_ready = 1'b1;
  logic       c_valid, c_last, c_busy;
  logic [3:0] c_data;
  logic [4:0] c_count;

  logic       mode_zero = 1'b0;

  weight_pattern_gen dut_a (
    .clk(clk), .nrst(nrst), .start(a_start), .mode(a_mode),
    .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data),
    .out_last(a_last), .busy(a_busy), .count(a_count)
  );

  weight_pattern_gen #(.N(4), .WMIN(4), .WMAX(4)) dut_b (
    .clk(clk), .nrst(nrst), .start(b_start), .mode(mode_zero),
    .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data),
    .out_last(b_last), .busy(b_busy), .count(b_count)
  );

  weight_pattern_gen #(.N(4), .WMIN(3), .WMAX(2)) dut_c (
    .clk(clk), .nrst(nrst), .start(c_start), .mode(mode_zero),
    .out_valid(c_valid), .out_ready(c_ready), .out_data(c_data),
    .out_last(c_last), .busy(c_busy), .count(c_count)
  );

  int errors = 0;
  int checks = 0;

  logic [4:0] q_a[$];
  logic [4:0] q_b[$];

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic bit model_qual(input int v, input int wmin, input int wmax, input int m);
    int pc;
    pc = 0;
    for (int i = 0; i < 4; i++) pc += (v >> i) & 1;
    return ((pc >= wmin) && (pc <= wmax)) != (m != 0);
  endfunction

  task automatic push_run(input int wmin, input int wmax, input int m, input int which);
    int seq[$];
    logic [4:0] e;
    for (int v = 0; v < 16; v++) if (model_qual(v, wmin, wmax, m)) seq.push_back(v);
    for (int i = 0; i < seq.size(); i++) begin
      e = {(i == seq.size() - 1) ? 1'b1 : 1'b0, 4'(seq[i])};
      if (which == 0) q_a.push_back(e);
      else q_b.push_back(e);
    end
  endtask

  // scoreboard consumers: compare each handshake against the expected queue
  always @(negedge clk) begin
    logic [4:0] e;
    if (a_valid && a_ready) begin
      if (q_a.size() == 0) check("a_unexpected", a_data, -1);
      else begin
        e = q_a.pop_front();
        check("a_data", a_data, e[3:0]);
        check("a_last", a_last, e[4]);
      end
    end
  end

  always @(negedge clk) begin
    logic [4:0] e;
    if (b_valid && b_ready) begin
      if (q_b.size() == 0) check("b_unexpected", b_data, -1);
      else begin
        e = q_b.pop_front();
        check("b_data", b_data, e[3:0]);
        check("b_last", b_last, e[4]);
      end
    end
  end

  always @(negedge clk) begin
    if (c_valid) check("c_valid_never", c_valid, 0);
  end

  task automatic pulse_a;
    @(negedge clk);
    a_start = 1'b1;
    @(posedge clk);
    #1 a_start = 1'b0;
  endtask

  task automatic wait_idle_a;
    int n;
    n = 0;
    while (a_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (a_busy) check("a_idle_timeout", 1, 0);
  endtask

  task automatic wait_data_a(input int val);
    int n;
    n = 0;
    while (!(a_valid && a_data == val) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!(a_valid && a_data == val)) check("a_wait_data_timeout", a_data, val);
  endtask

  initial begin
    int len;
    int n;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_valid", a_valid, 0);
    check("rst_data", a_data, 0);
    check("rst_last", a_last, 0);
    check("rst_busy", a_busy, 0);
    check("rst_count", a_count, 0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: default mode 0, first valid after E4, busy drops after E17
    a_mode = 1'b0;
    push_run(2, 3, 0, 0);
    pulse_a();
    for (int k = 0; k <= 17; k++) begin
      @(negedge clk);
      if (k == 3) check("t1_valid_e3", a_valid, 0);
      if (k == 4) begin
        check("t1_valid_e4", a_valid, 1);
        check("t1_data_e4", a_data, 3);
      end
      if (k == 16) check("t1_busy_e16", a_busy, 1);
      if (k == 17) check("t1_busy_e17", a_busy, 0);
    end
    check("t1_count", a_count, 10);
    check("t1_q_empty", q_a.size(), 0);

    // 2: mode 1, data 0 valid after E1
    a_mode = 1'b1;
    push_run(2, 3, 1, 0);
    pulse_a();
    for (int k = 0; k <= 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("t2_valid_e1", a_valid, 1);
        check("t2_data_e1", a_data, 0);
      end
    end
    wait_idle_a();
    check("t2_count", a_count, 6);
    check("t2_q_empty", q_a.size(), 0);

    // 3: backpressure while 5 is held
    a_mode = 1'b0;
    push_run(2, 3, 0, 0);
    pulse_a();
    wait_data_a(5);
    a_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_hold_valid", a_valid, 1);
      check("t3_hold_data", a_data, 5);
    end
    @(posedge clk);
    #1 a_ready = 1'b1;
    wait_idle_a();
    check("t3_count", a_count, 10);
    check("t3_q_empty", q_a.size(), 0);

    // 4: start and mode flip mid-run are ignored; a later start restarts
    a_mode = 1'b0;
    push_run(2, 3, 0, 0);
    pulse_a();
    wait_data_a(9);
    a_start = 1'b1;
    a_mode = 1'b1;
    @(posedge clk);
    #1 a_start = 1'b0;
    wait_idle_a();
    check("t4_count", a_count, 10);
    check("t4_q_empty", q_a.size(), 0);
    push_run(2, 3, 1, 0);
    pulse_a();
    check("t4_count_cleared", a_count, 0);
    check("t4_busy", a_busy, 1);
    wait_idle_a();
    check("t4_count2", a_count, 6);
    check("t4_q2_empty", q_a.size(), 0);

    // 5: asynchronous reset mid-run, then a fresh run
    a_mode = 1'b0;
    push_run(2, 3, 0, 0);
    pulse_a();
    wait_data_a(7);
    nrst = 1'b0;
    #1;
    check("t5_valid", a_valid, 0);
    check("t5_data", a_data, 0);
    check("t5_last", a_last, 0);
    check("t5_busy", a_busy, 0);
    check("t5_count", a_count, 0);
    q_a.delete();
    @(negedge clk);
    nrst = 1'b1;
    push_run(2, 3, 0, 0);
    pulse_a();
    wait_idle_a();
    check("t5_count_after", a_count, 10);
    check("t5_q_empty", q_a.size(), 0);

    // 6a: single-word range
    push_run(4, 4, 0, 1);
    @(negedge clk);
    b_start = 1'b1;
    @(posedge clk);
    #1 b_start = 1'b0;
    n = 0;
    while (b_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (b_busy) check("b_idle_timeout", 1, 0);
    check("t6_b_count", b_count, 1);
    check("t6_b_q_empty", q_b.size(), 0);

    // 6b: empty range
    @(negedge clk);
    c_start = 1'b1;
    @(posedge clk);
    #1 c_start = 1'b0;
    len = 0;
    n = 0;
    do begin
      @(negedge clk);
      if (c_busy) len++;
      n++;
    end while (c_busy && n < 60);
    check("t6_c_busy_len", len, 17);
    check("t6_c_count", c_count, 0);
    check("t6_c_last", c_last, 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
